pe_seq_ctrl: RTL and testbench

//  Sequencer for the PE_core matrix-vector datapath: walks weight/vector SRAMs, drives alu_start/cycle_num.

---
 rtl/pe_seq_ctrl_pkg.sv | 31 +++
 rtl/pe_seq_ctrl_if.sv | 47 ++++
 rtl/pe_seq_ctrl_delay.sv | 33 +++
 rtl/pe_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pe_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pe_seq_ctrl_pkg
//   Shared types and constants for the PE_core sequencer slice.
//   - state_t      : sequencer FSM states
//   - CYCLE_NUM_W  : width of the accumulation step index (K up to 512)
//   - DEF_*        : default latencies and address widths
//   - cnt_w()      : width of a counter that must hold 0..n-1
// ---------------------------------------------------------------------------
package pe_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned CYCLE_NUM_W      = 9;
  localparam int unsigned DEF_SRAM_RD_LAT  = 1;
  localparam int unsigned DEF_PE_LAT       = 1;
  localparam int unsigned DEF_W_ADDR_WIDTH = 13;
  localparam int unsigned DEF_V_ADDR_WIDTH = 9;
  localparam int unsigned DEF_O_ADDR_WIDTH = 4;

  // Bits needed for a counter running 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// pe_seq_ctrl_if
//   Bundles the sequencer's command, SRAM read, PE control and result
//   handshake signals.
//   master : the sequencer (drives SRAM reads, PE controls, status, out_valid)
//   slave  : the surroundings (cmd regs, SRAMs, PE_core, output writer)
//   Command : start, cfg_k_m1, cfg_tiles_m1 -> busy, done
//   SRAM    : w_ren/w_raddr, v_ren/v_raddr
//   PE_core : alu_start, cycle_num
//   Result  : out_valid, out_addr <-> out_ready
// ---------------------------------------------------------------------------
interface pe_seq_ctrl_if
  import pe_seq_ctrl_pkg::*;
#(
  parameter int unsigned W_ADDR_WIDTH = DEF_W_ADDR_WIDTH,
  parameter int unsigned V_ADDR_WIDTH = DEF_V_ADDR_WIDTH,
  parameter int unsigned O_ADDR_WIDTH = DEF_O_ADDR_WIDTH
);

  logic                    start;
  logic [CYCLE_NUM_W-1:0]  cfg_k_m1;
  logic [O_ADDR_WIDTH-1:0] cfg_tiles_m1;
  logic                    busy;
  logic                    done;
  logic                    w_ren;
  logic [W_ADDR_WIDTH-1:0] w_raddr;
  logic                    v_ren;
  logic [V_ADDR_WIDTH-1:0] v_raddr;
  logic                    alu_start;
  logic [CYCLE_NUM_W-1:0]  cycle_num;
  logic                    out_valid;
  logic                    out_ready;
  logic [O_ADDR_WIDTH-1:0] out_addr;

  modport master (
    input  start, cfg_k_m1, cfg_tiles_m1, out_ready,
    output busy, done, w_ren, w_raddr, v_ren, v_raddr,
           alu_start, cycle_num, out_valid, out_addr
  );

  modport slave (
    output start, cfg_k_m1, cfg_tiles_m1, out_ready,
    input  busy, done, w_ren, w_raddr, v_ren, v_raddr,
           alu_start, cycle_num, out_valid, out_addr
  );

endinterface

// File: rtl/pe_seq_ctrl_delay.sv
// ---------------------------------------------------------------------------
// pe_seq_ctrl_delay
//   Fixed-depth shift register that lines the read-issue strobe and step
//   index up with the cycle the SRAM data actually appears.
//   clk, srst : clock, synchronous active-high clear of every stage
//   din       : {ren, k} at issue time
//   dout      : {alu_start, cycle_num}, din delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module pe_seq_ctrl_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_p [DEPTH];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_p[i] <= '0;
    end else begin
      // stage 0 captures the issue-time beat; later stages shift it along
      pipe_p[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign dout = pipe_p[DEPTH-1];

endmodule

// File: rtl/pe_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pe_seq_ctrl
//   Sequencer for the PE_core matrix-vector datapath. For each row tile it
//   issues K weight/vector read pairs, re-times the PE controls to the SRAM
//   read latency, waits for the PE to drain and then offers the tile result
//   to the output writer with a valid/ready handshake.
//   clk  : clock
//   srst : synchronous active-high reset, aborts any run in progress
//   bus  : pe_seq_ctrl_if.master (command, SRAM reads, PE controls, result)
// ---------------------------------------------------------------------------
module pe_seq_ctrl
  import pe_seq_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE    = 16,
  parameter int unsigned K_ACCUM_DEPTH = 512,
  parameter int unsigned W_ADDR_WIDTH  = DEF_W_ADDR_WIDTH,
  parameter int unsigned V_ADDR_WIDTH  = DEF_V_ADDR_WIDTH,
  parameter int unsigned O_ADDR_WIDTH  = DEF_O_ADDR_WIDTH,
  parameter int unsigned SRAM_RD_LAT   = DEF_SRAM_RD_LAT,
  parameter int unsigned PE_LAT        = DEF_PE_LAT
) (
  input  logic          clk,
  input  logic          srst,
  pe_seq_ctrl_if.master bus
);

  // DRAIN lasts long enough for the last beat to cross the SRAM and the PE.
  localparam int unsigned DRAIN_CYC = SRAM_RD_LAT + PE_LAT;
  localparam int unsigned DRAIN_W   = cnt_w(DRAIN_CYC);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
  localparam int unsigned DL_W      = 1 + CYCLE_NUM_W;

  if (K_ACCUM_DEPTH > (1 << CYCLE_NUM_W) || ARRAY_SIZE < 1 ||
      SRAM_RD_LAT < 1 || PE_LAT < 1) begin : g_param_err
    $error("pe_seq_ctrl: unsupported parameter set");
  end

  state_t                  state;
  logic [CYCLE_NUM_W-1:0]  k;
  logic [CYCLE_NUM_W-1:0]  k_last;
  logic [O_ADDR_WIDTH-1:0] tile;
  logic [O_ADDR_WIDTH-1:0] tiles_last;
  logic [W_ADDR_WIDTH-1:0] w_addr;
  logic [DRAIN_W-1:0]      drain_cnt;
  logic                    ren;
  logic                    busy_r;
  logic                    done_r;
  logic                    out_valid_r;
  logic [DL_W-1:0]         dl_in;
  logic [DL_W-1:0]         dl_out;

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= ST_IDLE;
      k           <= '0;
      k_last      <= '0;
      tile        <= '0;
      tiles_last  <= '0;
      w_addr      <= '0;
      drain_cnt   <= '0;
      ren         <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            k_last     <= bus.cfg_k_m1;
            tiles_last <= bus.cfg_tiles_m1;
            tile       <= '0;
            k          <= '0;
            w_addr     <= '0;
            ren        <= 1'b1;
            busy_r     <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // The weight address simply runs on across tiles: tile*K + k
          // without a multiplier.
          w_addr <= w_addr + W_ADDR_WIDTH'(1);
          if (k == k_last) begin
            ren       <= 1'b0;
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            k <= k + CYCLE_NUM_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            out_valid_r <= 1'b1;
            state       <= ST_WB;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        ST_WB: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (tile == tiles_last) begin
              done_r <= 1'b1;
              state  <= ST_DONE;
            end else begin
              tile  <= tile + O_ADDR_WIDTH'(1);
              k     <= '0;
              ren   <= 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dl_in = {ren, k};

  pe_seq_ctrl_delay #(
    .DEPTH (SRAM_RD_LAT),
    .W     (DL_W)
  ) u_delay (
    .clk  (clk),
    .srst (srst),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.w_ren     = ren;
  assign bus.v_ren     = ren;
  assign bus.w_raddr   = w_addr;
  assign bus.v_raddr   = V_ADDR_WIDTH'(k);
  assign bus.alu_start = dl_out[DL_W-1];
  assign bus.cycle_num = dl_out[CYCLE_NUM_W-1:0];
  assign bus.out_valid = out_valid_r;
  assign bus.out_addr  = tile;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_seq_ctrl
//   Scoreboard bench for pe_seq_ctrl. Models the weight/vector SRAMs (one
//   cycle read latency) and a PE_core accumulator driven by alu_start and
//   cycle_num; expected read addresses, step indices and tile sums are queued
//   when a command is issued and popped as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_pe_seq_ctrl;
  import pe_seq_ctrl_pkg::*;

  localparam int WA = 13;
  localparam int VA = 9;
  localparam int OA = 4;

  logic clk  = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  pe_seq_ctrl_if #(.W_ADDR_WIDTH(WA), .V_ADDR_WIDTH(VA), .O_ADDR_WIDTH(OA)) bus ();

  pe_seq_ctrl #(
    .ARRAY_SIZE(16), .K_ACCUM_DEPTH(512), .W_ADDR_WIDTH(WA), .V_ADDR_WIDTH(VA),
    .O_ADDR_WIDTH(OA), .SRAM_RD_LAT(1), .PE_LAT(1)
  ) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: small signed values so products and sums stay exact.
  function automatic longint w_val(input int a);
    return longint'((a * 7 + 3) % 19) - 9;
  endfunction
  function automatic longint v_val(input int a);
    return longint'((a * 5 + 2) % 11) - 5;
  endfunction

  typedef struct { int w; int v; } rd_t;
  typedef struct { int addr; longint sum; } tl_t;
  rd_t rq[$];
  int  cq[$];
  tl_t tq[$];

  // SRAM + PE_core behavioural model
  longint w_rd = 0, v_rd = 0, acc = 0;
  always @(posedge clk) begin
    if (bus.w_ren) w_rd <= w_val(int'(bus.w_raddr));
    if (bus.v_ren) v_rd <= v_val(int'(bus.v_raddr));
    if (bus.alu_start) acc <= ((bus.cycle_num == 0) ? 64'sd0 : acc) + w_rd * v_rd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t_ren = -1, t_alu = -1, t_ov = -1, done_cnt = 0, max_cn = 0;

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (!srst) begin
      if (bus.w_ren) begin
        if (t_ren < 0) t_ren = cyc;
        if (rq.size() == 0) check("ren_extra", 1, 0);
        else begin
          rd_t e;
          e = rq.pop_front();
          check("w_raddr", longint'(bus.w_raddr), e.w);
          check("v_raddr", longint'(bus.v_raddr), e.v);
          check("v_ren", longint'(bus.v_ren), 1);
        end
      end
      if (bus.alu_start) begin
        if (t_alu < 0) t_alu = cyc;
        if (int'(bus.cycle_num) > max_cn) max_cn = int'(bus.cycle_num);
        if (cq.size() == 0) check("alu_extra", 1, 0);
        else check("cycle_num", longint'(bus.cycle_num), cq.pop_front());
      end
      if (bus.out_valid && t_ov < 0) t_ov = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (tq.size() == 0) check("out_extra", 1, 0);
        else begin
          tl_t e;
          e = tq.pop_front();
          check("out_addr", longint'(bus.out_addr), e.addr);
          check("mul_outcome", acc, e.sum);
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic push_cmd(input int k_m1, input int tiles_m1);
    int kk = k_m1 + 1;
    for (int t = 0; t <= tiles_m1; t++) begin
      longint s = 0;
      for (int k = 0; k < kk; k++) begin
        rq.push_back('{w: t * kk + k, v: k});
        cq.push_back(k);
        s += w_val(t * kk + k) * v_val(k);
      end
      tq.push_back('{addr: t, sum: s});
    end
  endtask

  task automatic issue(input int k_m1, input int tiles_m1, output int c0);
    @(negedge clk);
    t_ren = -1; t_alu = -1; t_ov = -1; done_cnt = 0; max_cn = 0;
    bus.cfg_k_m1     = 9'(k_m1);
    bus.cfg_tiles_m1 = 4'(tiles_m1);
    bus.start        = 1'b1;
    c0               = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_on", longint'(bus.busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("busy_idle", longint'(bus.busy), 0);
    check("rd_left", rq.size(), 0);
    check("cn_left", cq.size(), 0);
    check("tile_left", tq.size(), 0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"},      longint'(bus.busy), 0);
    check({pfx, "_done"},      longint'(bus.done), 0);
    check({pfx, "_w_ren"},     longint'(bus.w_ren), 0);
    check({pfx, "_v_ren"},     longint'(bus.v_ren), 0);
    check({pfx, "_w_raddr"},   longint'(bus.w_raddr), 0);
    check({pfx, "_v_raddr"},   longint'(bus.v_raddr), 0);
    check({pfx, "_alu_start"}, longint'(bus.alu_start), 0);
    check({pfx, "_cycle_num"}, longint'(bus.cycle_num), 0);
    check({pfx, "_out_valid"}, longint'(bus.out_valid), 0);
    check({pfx, "_out_addr"},  longint'(bus.out_addr), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bus.start = 1'b0; bus.cfg_k_m1 = '0; bus.cfg_tiles_m1 = '0; bus.out_ready = 1'b1;
    srst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    srst = 1'b0;

    // 1: K=5, one tile, latency map
    push_cmd(4, 0);
    issue(4, 0, c0);
    wait_done(100);
    check("t1_ren_lat", t_ren - c0, 1);
    check("t1_alu_lat", t_alu - c0, 2);
    check("t1_ov_lat",  t_ov - c0, 8);

    // 2: K=4, three tiles, continuous weight addressing
    push_cmd(3, 2);
    issue(3, 2, c0);
    wait_done(200);
    check("t2_ov_lat", t_ov - c0, 7);

    // 3: K=3, two tiles, writer stalls tile 0 for 10 cycles
    push_cmd(2, 1);
    bus.out_ready = 1'b0;
    issue(2, 1, c0);
    for (int n = 0; n < 50 && !bus.out_valid; n++) @(negedge clk);
    check("t3_ov_seen", longint'(bus.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", longint'(bus.out_valid), 1);
      check("t3_hold_addr",  longint'(bus.out_addr), 0);
      check("t3_stall_ren",  longint'(bus.w_ren), 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_done(200);

    // 4: K=1, start pulse during FETCH must be ignored
    push_cmd(0, 0);
    issue(0, 0, c0);
    bus.cfg_k_m1 = 9'd5; bus.cfg_tiles_m1 = 4'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(100);
    check("t4_alu_lat", t_alu - c0, 2);
    check("t4_ov_lat",  t_ov - c0, 4);

    // 5: srst three cycles into a K=8 run, then a clean K=2 run
    push_cmd(7, 0);
    issue(7, 0, c0);
    repeat (2) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    check_zero("abort");
    rq.delete(); cq.delete(); tq.delete();
    done_cnt = 0;
    srst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_done", done_cnt, 0);
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_ov", longint'(bus.out_valid), 0);
    push_cmd(1, 0);
    issue(1, 0, c0);
    wait_done(100);

    // 6: maximum depth K=512
    push_cmd(511, 0);
    issue(511, 0, c0);
    wait_done(800);
    check("t6_max_cycle_num", max_cn, 511);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
